load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Initiator side of the data-memory port. The multicycle CPU control issues one load or store at a time through a valid/ready request handshake. This block sequences the memory's port signals (we, AddrSrc, MemOp, addr, wd) and returns the result with a one-cycle response pulse. The memory places sb/sh data only in the low lanes of a word, so this block performs read-modify-write for sub-word stores at non-zero offsets. It also flags misaligned or illegal requests without touching memory.

Parameters:
RMW_EN, 1, 1 = sub-word stores at non-zero byte offset use read-modify-write; 0 = such stores return an error.

Ports:
clk  in  1  clock; all state changes on posedge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  block idle and can accept; equals (state==IDLE) && !reset
req_we  in  1  1 = store, 0 = load
req_op  in  3  MemOp encoding: 001 b, 010 h, 011 w, 100 bu, 101 hu
req_data_seg  in  1  passed through as mem_AddrSrc (1 = data segment)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  valid with resp_valid; 1 = misaligned or illegal request
resp_rdata  out  32  load result; 0 for stores and errors; held between responses
mem_we  out  1  memory write enable
mem_AddrSrc  out  1  memory address-source select
mem_MemOp  out  3  memory access type
mem_addr  out  32  memory byte address
mem_wd  out  32  memory write data
mem_rd  in  32  memory read data; combinational from mem_addr/mem_MemOp

Behaviour:
- Reset:
  - state=IDLE.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - All request latches=0.
  - mem_we is gated combinationally by !reset, so no write occurs on an edge where reset=1, including reset arriving mid-operation.
- Accept: on a posedge with req_valid && req_ready, latch we/op/data_seg/addr/wdata. The next state is chosen by classification at accept time.
- Error classification:
  - Illegal op: load op in {000,110,111}; store op not in {001,010,011}.
  - Misaligned: h/hu/sh with addr[0]=1; w/sw with addr[1:0]!=0.
  - Not permitted: sub-word store at non-zero offset when RMW_EN=0.
  - Any of these -> DONE with err=1; memory is never accessed.
- States:
  - IDLE: mem_we=0; other mem outputs are 0.
  - LOAD: mem_MemOp=op, mem_addr=addr, mem_AddrSrc=data_seg. Capture mem_rd into resp_rdata at cycle end. -> DONE.
  - WRITE: direct store for sw, and for sb/sh at offset 0. mem_we=1, mem_MemOp=op, mem_wd=wdata. -> DONE.
  - RMW_RD: mem_MemOp=011, mem_addr = addr with [1:0] cleared. Capture mem_rd into merge register. -> RMW_WR.
  - RMW_WR: mem_we=1, mem_MemOp=011, mem_wd=merged word. -> DONE.
  - DONE: resp_valid=1 for exactly one cycle; resp_err set as classified. -> IDLE.
- Merge rules:
  - sb, offset k: bits [8k+7:8k] = wdata[7:0]; other bytes unchanged.
  - sh, offset 2: bits [31:16] = wdata[15:0].
- Latency from accept edge to resp_valid high:
  - error: 1 cycle
  - load or direct store: 2 cycles
  - RMW store: 3 cycles
- req_ready is low from accept through DONE and returns high in the IDLE cycle after DONE. Maximum throughput is one request per 3 / 4 cycles.
- resp_rdata:
  - Loads: the memory's sign/zero-extended value, unmodified.
  - Stores and errors: 0.
- Request inputs are ignored while not IDLE. Changes on the req_* inputs after accept have no effect.
- Address wrap is the memory's concern; mem_addr is passed unmodified except the RMW word alignment.

Test Plan:
1. Preload word 0x11223344 at data addr 0x8; issue sb wdata=0xAB at 0x9. Required: RMW_RD, RMW_WR, then DONE; word becomes 0x1122AB44; resp_valid 3 cycles after accept; resp_err=0.
2. Then sh 0xBEEF at 0xA, followed by lb at 0x9. Required: word becomes 0xBEEFAB44; lb returns resp_rdata=0xFFFFFFAB; lbu at 0x9 returns 0x000000AB.
3. Issue lw at 0x6, and separately sh at 0x3. Required: resp_err=1 one cycle after accept; mem_we never asserted; resp_rdata=0.
4. Issue sw 0xCAFEF00D at 0x10 with req_valid held high for back-to-back lw at 0x10. Required: store completes in 2 cycles; second request accepted on the IDLE edge after DONE; lw returns 0xCAFEF00D.
5. Assert reset during RMW_WR of an sb to 0x9. Required: word unchanged (0x11223344); state=IDLE; resp_valid=0; req_ready=1 after reset deasserts.
6. Set RMW_EN=0 and issue sb at 0x9. Required: resp_err=1 with no memory write; sb at 0x8 writes the low byte directly with 2-cycle latency.

Source files
------------

// File: rtl/load_store_unit.sv
// Data-memory initiator: sequences one load/store at a time onto the memory port.
// Sub-word stores at non-zero offset go through a read-modify-write when RMW_EN is set.
module load_store_unit #(
  parameter bit RMW_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic        req_data_seg,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_we,
  output logic        mem_AddrSrc,
  output logic [2:0]  mem_MemOp,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  // state  | meaning
  // IDLE   | waiting for a request, req_ready high
  // LOAD   | memory read, result captured at cycle end
  // WRITE  | direct store (sw, or sb/sh at offset 0)
  // RMW_RD | aligned word read, merged with store data
  // RMW_WR | merged word written back
  // DONE   | one-cycle response
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RMW_RD, RMW_WR, DONE} state_t;

  localparam logic [2:0] OP_B  = 3'b001;
  localparam logic [2:0] OP_H  = 3'b010;
  localparam logic [2:0] OP_W  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  state_t      state, state_nxt;
  logic        we_q;
  logic [2:0]  op_q;
  logic        seg_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic        err_q;
  logic        mem_we_int;

  logic accept;
  logic op_illegal;
  logic misaligned;
  logic subword_off;
  logic cls_err;

  assign req_ready  = (state == IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == DONE) && !reset;
  assign resp_err   = resp_valid && err_q;
  assign mem_we     = mem_we_int && !reset;

  function automatic logic [31:0] merge_word(input logic [31:0] word, input logic [31:0] wd,
                                             input logic [2:0] op, input logic [1:0] off);
    logic [31:0] m;
    m = word;
    if (op == OP_H) begin
      if (off[1]) m[31:16] = wd[15:0];
      else        m[15:0]  = wd[15:0];
    end else begin
      case (off)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end
    return m;
  endfunction

  always_comb begin
    if (req_we) op_illegal = !(req_op inside {OP_B, OP_H, OP_W});
    else        op_illegal = !(req_op inside {OP_B, OP_H, OP_W, OP_BU, OP_HU});
    misaligned  = ((req_op == OP_H || req_op == OP_HU) && req_addr[0]) ||
                  ((req_op == OP_W) && (req_addr[1:0] != 2'b00));
    subword_off = req_we && (req_op == OP_B || req_op == OP_H) && (req_addr[1:0] != 2'b00);
    cls_err     = op_illegal || misaligned || (subword_off && !RMW_EN);
  end

  always_comb begin
    state_nxt   = state;
    mem_we_int  = 1'b0;
    mem_AddrSrc = 1'b0;
    mem_MemOp   = 3'b000;
    mem_addr    = 32'h0;
    mem_wd      = 32'h0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cls_err)          state_nxt = DONE;
          else if (!req_we)     state_nxt = LOAD;
          else if (subword_off) state_nxt = RMW_RD;
          else                  state_nxt = WRITE;
        end
      end
      LOAD: begin
        mem_AddrSrc = seg_q;
        mem_MemOp   = op_q;
        mem_addr    = addr_q;
        state_nxt   = DONE;
      end
      WRITE: begin
        mem_we_int  = 1'b1;
        mem_AddrSrc = seg_q;
        mem_MemOp   = op_q;
        mem_addr    = addr_q;
        mem_wd      = wdata_q;
        state_nxt   = DONE;
      end
      RMW_RD: begin
        mem_AddrSrc = seg_q;
        mem_MemOp   = OP_W;
        mem_addr    = {addr_q[31:2], 2'b00};
        state_nxt   = RMW_WR;
      end
      RMW_WR: begin
        mem_we_int  = 1'b1;
        mem_AddrSrc = seg_q;
        mem_MemOp   = OP_W;
        mem_addr    = {addr_q[31:2], 2'b00};
        mem_wd      = merge_q;
        state_nxt   = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      op_q       <= 3'b000;
      seg_q      <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      merge_q    <= 32'h0;
      err_q      <= 1'b0;
      resp_rdata <= 32'h0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= req_we;
        op_q    <= req_op;
        seg_q   <= req_data_seg;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= cls_err;
        if (cls_err) resp_rdata <= 32'h0;
      end
      case (state)
        LOAD:          resp_rdata <= mem_rd;
        WRITE, RMW_WR: resp_rdata <= 32'h0;
        RMW_RD:        merge_q    <= merge_word(mem_rd, wdata_q, op_q, addr_q[1:0]);
        default:       ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word-array memory model, directed requests, and a
// scoreboard whose monitor pops one expectation per response pulse.
module tb_load_store_unit;

  localparam logic [2:0] OP_B  = 3'b001;
  localparam logic [2:0] OP_H  = 3'b010;
  localparam logic [2:0] OP_W  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_op = 3'b000;
  logic        req_data_seg = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] mem_rd;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_valid, b_valid;
  logic        a_ready, b_ready, a_rv, b_rv, a_err, b_err, a_we, b_we, a_seg, b_seg;
  logic [2:0]  a_op, b_op;
  logic [31:0] a_rdata, b_rdata, a_addr, b_addr, a_wd, b_wd;

  assign a_valid = req_valid && !sel;
  assign b_valid = req_valid && sel;

  load_store_unit #(.RMW_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .req_valid(a_valid), .req_ready(a_ready), .req_we(req_we),
    .req_op(req_op), .req_data_seg(req_data_seg), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(a_rv), .resp_err(a_err), .resp_rdata(a_rdata), .mem_we(a_we),
    .mem_AddrSrc(a_seg), .mem_MemOp(a_op), .mem_addr(a_addr), .mem_wd(a_wd), .mem_rd(mem_rd));

  load_store_unit #(.RMW_EN(1'b0)) dut_normw (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_ready(b_ready), .req_we(req_we),
    .req_op(req_op), .req_data_seg(req_data_seg), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(b_rv), .resp_err(b_err), .resp_rdata(b_rdata), .mem_we(b_we),
    .mem_AddrSrc(b_seg), .mem_MemOp(b_op), .mem_addr(b_addr), .mem_wd(b_wd), .mem_rd(mem_rd));

  logic        cur_ready, cur_rv, cur_err, cur_we, cur_seg;
  logic [2:0]  cur_op;
  logic [31:0] cur_rdata, cur_addr, cur_wd;

  always_comb begin
    cur_ready = sel ? b_ready : a_ready;
    cur_rv    = sel ? b_rv    : a_rv;
    cur_err   = sel ? b_err   : a_err;
    cur_rdata = sel ? b_rdata : a_rdata;
    cur_we    = sel ? b_we    : a_we;
    cur_seg   = sel ? b_seg   : a_seg;
    cur_op    = sel ? b_op    : a_op;
    cur_addr  = sel ? b_addr  : a_addr;
    cur_wd    = sel ? b_wd    : a_wd;
  end

  // Memory model: reads extract the addressed lane, writes land only in low lanes.
  logic [31:0] dmem [16];
  logic [31:0] imem [16];
  logic        pre_en = 1'b0;
  logic [3:0]  pre_idx = 4'd0;
  logic [31:0] pre_val = 32'h0;
  int          wr_cnt = 0;
  logic [31:0] mw;
  logic [7:0]  mb;
  logic [15:0] mh;

  always_comb begin
    mw = cur_seg ? dmem[cur_addr[5:2]] : imem[cur_addr[5:2]];
    mb = mw[{cur_addr[1:0], 3'b000} +: 8];
    mh = cur_addr[1] ? mw[31:16] : mw[15:0];
    case (cur_op)
      OP_B:    mem_rd = {{24{mb[7]}}, mb};
      OP_H:    mem_rd = {{16{mh[15]}}, mh};
      OP_W:    mem_rd = mw;
      OP_BU:   mem_rd = {24'h0, mb};
      OP_HU:   mem_rd = {16'h0, mh};
      default: mem_rd = 32'h0;
    endcase
  end

  function automatic logic [31:0] lane_write(input logic [31:0] w, input logic [31:0] wd,
                                             input logic [2:0] op);
    case (op)
      OP_B:    return {w[31:8], wd[7:0]};
      OP_H:    return {w[31:16], wd[15:0]};
      default: return wd;
    endcase
  endfunction

  always @(posedge clk) begin
    if (pre_en) dmem[pre_idx] <= pre_val;
    else if (cur_we) begin
      wr_cnt <= wr_cnt + 1;
      if (cur_seg) dmem[cur_addr[5:2]] <= lane_write(dmem[cur_addr[5:2]], cur_wd, cur_op);
      else         imem[cur_addr[5:2]] <= lane_write(imem[cur_addr[5:2]], cur_wd, cur_op);
    end
  end

  // Scoreboard and check queues, drained by the monitor only.
  typedef struct {int acc; int lat; logic err; logic [31:0] rdata;} exp_t;
  typedef struct {string name; logic [31:0] act; logic [31:0] exp;} chk_t;
  exp_t sb_q[$];
  chk_t chk_q[$];
  exp_t e;
  chk_t c;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(negedge clk) begin
    if (cur_rv) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding (err=%0b rdata=%h)",
                 cur_err, cur_rdata);
      end else begin
        e = sb_q.pop_front();
        n_checks += 3;
        if (cur_err !== e.err) begin
          n_fail++;
          $display("FAIL resp_err: got %0b expected %0b (accept cycle %0d)", cur_err, e.err, e.acc);
        end
        if (cur_rdata !== e.rdata) begin
          n_fail++;
          $display("FAIL resp_rdata: got %h expected %h (accept cycle %0d)", cur_rdata, e.rdata, e.acc);
        end
        if (cyc - e.acc + 1 != e.lat) begin
          n_fail++;
          $display("FAIL latency: got %0d expected %0d (accept cycle %0d)", cyc - e.acc + 1, e.lat, e.acc);
        end
      end
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      n_checks++;
      if (c.act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", c.name, c.act, c.exp);
      end
    end
  end

  task automatic push_chk(input string n, input logic [31:0] a, input logic [31:0] x);
    chk_q.push_back('{name: n, act: a, exp: x});
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [2:0] opc, input logic [31:0] addr,
                       input logic [31:0] wd, input logic x_err, input logic [31:0] x_rd,
                       input int lat, input bit hold, input bit expect_resp, output int acc);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_op = opc; req_data_seg = 1'b1;
    req_addr = addr; req_wdata = wd;
    n = 0;
    while (!cur_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cur_ready) push_chk("ready_timeout", 32'(cur_ready), 32'd1);
    acc = cyc + 1;
    if (expect_resp) sb_q.push_back('{acc: acc, lat: lat, err: x_err, rdata: x_rd});
    @(posedge clk);
    #1;
    // Scramble request fields so any use of live inputs after accept shows up.
    req_valid = hold; req_we = ~we; req_op = OP_W; req_data_seg = 1'b0;
    req_addr = 32'hFFFF_FFFC; req_wdata = 32'h0;
  endtask

  task automatic req(input logic we, input logic [2:0] opc, input logic [31:0] addr,
                     input logic [31:0] wd, input logic x_err, input logic [31:0] x_rd, input int lat);
    int acc;
    issue(we, opc, addr, wd, x_err, x_rd, lat, 1'b0, 1'b1, acc);
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    push_chk("resp_drain", 32'(sb_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, w0;
    repeat (3) @(negedge clk);
    push_chk("rst_req_ready", 32'(cur_ready), 32'd0);
    push_chk("rst_resp_valid", 32'(cur_rv), 32'd0);
    push_chk("rst_resp_rdata", cur_rdata, 32'd0);
    push_chk("rst_mem_addr", cur_addr, 32'd0);
    reset = 1'b0;
    #1 push_chk("ready_after_rst", 32'(cur_ready), 32'd1);

    // RMW byte and half stores, then sign/zero-extended loads
    preload(4'd2, 32'h1122_3344);
    req(1'b1, OP_B, 32'h9, 32'h0000_00AB, 1'b0, 32'h0, 3);
    settle();
    push_chk("word_after_sb9", dmem[2], 32'h1122_AB44);
    req(1'b1, OP_H, 32'hA, 32'h0000_BEEF, 1'b0, 32'h0, 3);
    settle();
    push_chk("word_after_shA", dmem[2], 32'hBEEF_AB44);
    req(1'b0, OP_B,  32'h9, 32'h0, 1'b0, 32'hFFFF_FFAB, 2);
    req(1'b0, OP_BU, 32'h9, 32'h0, 1'b0, 32'h0000_00AB, 2);
    req(1'b0, OP_H,  32'hA, 32'h0, 1'b0, 32'hFFFF_BEEF, 2);
    req(1'b0, OP_HU, 32'hA, 32'h0, 1'b0, 32'h0000_BEEF, 2);
    req(1'b1, OP_B,  32'hB, 32'h1234_5680, 1'b0, 32'h0, 3);
    req(1'b1, OP_B,  32'hA, 32'h0000_005A, 1'b0, 32'h0, 3);
    req(1'b0, OP_B,  32'hB, 32'h0, 1'b0, 32'hFFFF_FF80, 2);
    req(1'b0, OP_W,  32'h8, 32'h0, 1'b0, 32'h805A_AB44, 2);
    settle();
    push_chk("word_after_sb_ab", dmem[2], 32'h805A_AB44);

    // Misaligned and illegal requests never touch memory
    w0 = wr_cnt;
    req(1'b0, OP_W,   32'h6, 32'h0, 1'b1, 32'h0, 1);
    req(1'b1, OP_H,   32'h3, 32'hFFFF, 1'b1, 32'h0, 1);
    req(1'b1, OP_W,   32'h2, 32'hFFFF_FFFF, 1'b1, 32'h0, 1);
    req(1'b0, OP_H,   32'h9, 32'h0, 1'b1, 32'h0, 1);
    req(1'b0, 3'b110, 32'h8, 32'h0, 1'b1, 32'h0, 1);
    req(1'b0, 3'b000, 32'h8, 32'h0, 1'b1, 32'h0, 1);
    req(1'b1, OP_BU,  32'h8, 32'hFF, 1'b1, 32'h0, 1);
    settle();
    push_chk("no_write_on_err", 32'(wr_cnt - w0), 32'd0);
    push_chk("word_after_errs", dmem[2], 32'h805A_AB44);

    // Direct store with valid held high into a back-to-back load
    issue(1'b1, OP_W, 32'h10, 32'hCAFE_F00D, 1'b0, 32'h0, 2, 1'b1, 1'b1, a1);
    issue(1'b0, OP_W, 32'h10, 32'h0, 1'b0, 32'hCAFE_F00D, 2, 1'b0, 1'b1, a2);
    settle();
    push_chk("b2b_accept_gap", 32'(a2 - a1), 32'd3);
    push_chk("word_after_sw", dmem[4], 32'hCAFE_F00D);
    req(1'b1, OP_H, 32'h10, 32'h0000_1234, 1'b0, 32'h0, 2);
    req(1'b0, OP_W, 32'h10, 32'h0, 1'b0, 32'hCAFE_1234, 2);
    settle();

    // Reset landing in RMW_WR suppresses the write and the response
    preload(4'd2, 32'h1122_3344);
    w0 = wr_cnt;
    issue(1'b1, OP_B, 32'h9, 32'h0000_0055, 1'b0, 32'h0, 0, 1'b0, 1'b0, a1);
    @(posedge clk);
    @(negedge clk);
    push_chk("rmw_wr_we_live", 32'(cur_we), 32'd1);
    reset = 1'b1;
    #1 push_chk("rst_gates_we", 32'(cur_we), 32'd0);
    @(negedge clk);
    push_chk("rst_mid_resp_valid", 32'(cur_rv), 32'd0);
    push_chk("rst_mid_ready", 32'(cur_ready), 32'd0);
    reset = 1'b0;
    #1 push_chk("ready_after_mid_rst", 32'(cur_ready), 32'd1);
    repeat (3) @(negedge clk);
    push_chk("word_after_rst", dmem[2], 32'h1122_3344);
    push_chk("no_write_on_rst", 32'(wr_cnt - w0), 32'd0);

    // RMW disabled: offset sub-word stores error, offset-0 stores go direct
    @(negedge clk);
    sel = 1'b1;
    w0 = wr_cnt;
    req(1'b1, OP_B, 32'h9, 32'h0000_00AB, 1'b1, 32'h0, 1);
    req(1'b1, OP_H, 32'hA, 32'h0000_BEEF, 1'b1, 32'h0, 1);
    settle();
    push_chk("normw_no_write", 32'(wr_cnt - w0), 32'd0);
    req(1'b1, OP_B, 32'h8, 32'h0000_0077, 1'b0, 32'h0, 2);
    req(1'b0, OP_BU, 32'h8, 32'h0, 1'b0, 32'h0000_0077, 2);
    settle();
    push_chk("normw_word_sb8", dmem[2], 32'h1122_3377);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
